// File: rtl/asap7_compat_dffasr_pipe.sv
// asap7_compat_dffasr_pipe: async set/reset register pipeline with valid/ready and bubble collapsing
// Optional scan chain (SE/SI/SO) enabled by defining ASAP7_COMPAT_SCAN_EN.
module asap7_compat_dffasr_pipe #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter logic [WIDTH-1:0] SET_VAL = '1
) (
  input  logic             CLK,
  input  logic             RESETN,
  input  logic             SETN,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] D,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] QN
`ifdef ASAP7_COMPAT_SCAN_EN
  ,
  input  logic             SE,
  input  logic             SI,
  output logic             SO
`endif
);
  localparam int NW = WIDTH * DEPTH;
  logic [NW-1:0] data_q, data_d, data_up;
  logic [DEPTH-1:0] vld_q, vld_d, vld_up, adv;
  logic se, si;
`ifdef ASAP7_COMPAT_SCAN_EN
  assign se = SE;
  assign si = SI;
  assign SO = data_q[NW-1];
`else
  assign se = 1'b0;
  assign si = 1'b0;
`endif
  if (DEPTH < 1) begin : g_bad_depth
    $error("DEPTH must be >= 1");
  end
  // A stage advances when it or any stage downstream of it is a bubble, or the sink accepts.
  for (genvar g = 0; g < DEPTH; g++) begin : g_adv
    assign adv[g] = out_ready | ~&vld_q[DEPTH-1:g];
  end
  assign data_up = NW'({data_q, D});
  assign vld_up = DEPTH'({vld_q, in_valid});
  assign in_ready = RESETN & SETN & ~se & adv[0];
  assign out_valid = vld_q[DEPTH-1] & ~se;
  assign Q = data_q[NW-1 -: WIDTH];
  assign QN = ~Q;
  always_comb begin
    data_d = data_q;
    vld_d = vld_q;
    if (se) data_d = NW'({data_q, si});
    else if (SETN)
      for (int i = 0; i < DEPTH; i++)
        if (adv[i]) begin
          data_d[i*WIDTH +: WIDTH] = data_up[i*WIDTH +: WIDTH];
          vld_d[i] = vld_up[i];
        end
  end
  always_ff @(posedge CLK or negedge RESETN or negedge SETN)
    if (!RESETN) data_q <= {DEPTH{RESET_VAL}};
    else if (!SETN) data_q <= {DEPTH{SET_VAL}};
    else data_q <= data_d;
  always_ff @(posedge CLK or negedge RESETN)
    if (!RESETN) vld_q <= '0;
    else vld_q <= vld_d;
endmodule

// File: tb/tb_asap7_compat_dffasr_pipe.sv
// tb_asap7_compat_dffasr_pipe: scoreboard bench; the reference is an in-order word queue of capacity DEPTH.
module tb_asap7_compat_dffasr_pipe;
  localparam int W = 8, DP = 2;
  logic CLK = 0, RESETN = 1, SETN = 1, in_valid = 0, out_ready = 0, SE = 0, SI = 0;
  logic [W-1:0] D = '0, Q, QN;
  logic in_ready, out_valid;
`ifdef ASAP7_COMPAT_SCAN_EN
  logic SO;
  logic [15:0] pat = 16'hA53C;
`endif
  typedef struct { logic [W-1:0] w; int t; } ent_t;
  ent_t exp_q[$];
  int checks = 0, failures = 0, cyc = 0, ov_cnt = 0;
  bit exact = 0;

  asap7_compat_dffasr_pipe #(.WIDTH(W), .DEPTH(DP)) dut (
    .CLK(CLK), .RESETN(RESETN), .SETN(SETN), .in_valid(in_valid), .in_ready(in_ready),
    .D(D), .out_valid(out_valid), .out_ready(out_ready), .Q(Q), .QN(QN)
`ifdef ASAP7_COMPAT_SCAN_EN
    , .SE(SE), .SI(SI), .SO(SO)
`endif
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic drain();
    in_valid = 0;
    out_ready = 1;
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) tick();
    chk("drain_left", exp_q.size(), 0);
    chk("drain_ov", out_valid, 0);
  endtask

  // Monitor: the queue holds accepted words in order; at most DP can be in flight.
  always @(negedge CLK) if (RESETN && SETN) begin
    ent_t e;
    cyc++;
    chk("in_ready", in_ready, (exp_q.size() < DP || out_ready) && !SE);
    chk("qn_inverse", QN ^ Q, 8'hFF);
    if (SE) chk("ov_scan", out_valid, 0);
    else if (exp_q.size() == DP) chk("ov_full", out_valid, 1);
    if (out_valid) begin
      ov_cnt++;
      if (exp_q.size() == 0) chk("ov_empty", out_valid, 0);
      else if (out_ready) begin
        e = exp_q.pop_front();
        chk("q_data", Q, e.w);
        if (exact) chk("latency", cyc - e.t, DP);
        else chk("min_latency", (cyc - e.t) >= DP, 1);
      end
    end
    if (in_valid && in_ready) exp_q.push_back('{D, cyc});
  end

  initial begin
    #1 RESETN = 0;
    #1;
    chk("rst_q", Q, 8'h00);
    chk("rst_qn", QN, 8'hFF);
    chk("rst_ov", out_valid, 0);
    chk("rst_ir", in_ready, 0);
    tick();
    tick();
    RESETN = 1;
    exact = 1;
    out_ready = 1;
    ov_cnt = 0;
    in_valid = 1;
    D = 8'hA5;
    tick();
    D = 8'h3C;
    tick();
    in_valid = 0;
    repeat (4) tick();
    chk("stream_ov_cycles", ov_cnt, 2);
    exact = 0;
    out_ready = 0;
    in_valid = 1;
    repeat (4) begin
      D = W'($urandom);
      tick();
    end
    in_valid = 0;
    chk("stall_ir", in_ready, 0);
    chk("stall_ov", out_valid, 1);
    #1 SETN = 0;
    #1;
    chk("set_q", Q, 8'hFF);
    chk("set_qn", QN, 8'h00);
    chk("set_ir", in_ready, 0);
    chk("set_ov", out_valid, 1);
    #1 SETN = 1;
    foreach (exp_q[i]) exp_q[i].w = 8'hFF;
    chk("set_hold_q", Q, 8'hFF);
    tick();
    drain();
`ifdef ASAP7_COMPAT_SCAN_EN
    out_ready = 0;
    in_valid = 1;
    D = 8'hA5;
    tick();
    D = 8'h3C;
    tick();
    in_valid = 0;
    SE = 1;
    for (int k = 0; k < 16; k++) begin
      SI = (k % 2) == 0;
      #1;
      chk("scan_so", SO, pat[15-k]);
      chk("scan_ov", out_valid, 0);
      tick();
    end
    SE = 0;
    #1;
    chk("scan_q", Q, 8'hAA);
    chk("scan_ov_after", out_valid, 1);
    foreach (exp_q[i]) exp_q[i].w = 8'hAA;
    drain();
`endif
    out_ready = 0;
    in_valid = 1;
    repeat (3) begin
      D = W'($urandom);
      tick();
    end
    in_valid = 0;
    #1 SETN = 0;
    RESETN = 0;
    #1;
    chk("midrst_q", Q, 8'h00);
    chk("midrst_qn", QN, 8'hFF);
    chk("midrst_ov", out_valid, 0);
    chk("midrst_ir", in_ready, 0);
    SETN = 1;
    #1 RESETN = 1;
    exp_q.delete();
    out_ready = 1;
    repeat (3) begin
      tick();
      chk("post_rst_ov", out_valid, 0);
    end
    repeat (400) begin
      in_valid = 1'($urandom_range(0, 1));
      out_ready = $urandom_range(0, 3) != 0;
      D = W'($urandom);
      tick();
    end
    drain();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
